fifo_status: RTL

Parametrised synchronous FIFO with occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the next-generation buffer for stream paths between producer/consumer blocks. Its status outputs are meant to drive flow control and debug monitors without external counters. Read data is first-word-fall-through: the head word is visible on r_data whenever the FIFO is not empty.

---
 rtl/fifo_status_pkg.sv | 33 +++
 rtl/fifo_status_mem.sv | 27 ++
 rtl/fifo_status.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fifo_status_pkg.sv
// Shared FIFO definitions: depth and count-width rules, default thresholds and
// the level-flag bundle used by fifo_status and other FIFO variants.
package fifo_status_pkg;

    // Number of entries for an address width of w bits.
    function automatic int fifo_depth(input int w);
        return 1 << w;
    endfunction

    // The occupancy counter must hold 0..D inclusive, so it needs one more bit than the pointers.
    function automatic int count_width(input int w);
        return w + 1;
    endfunction

    function automatic int default_af_level(input int w);
        return fifo_depth(w) - 2;
    endfunction

    function automatic int default_ae_level(input int w);
        return (w > 0) ? 2 : 0;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } level_flags_t;

    localparam level_flags_t LEVEL_FLAGS_RESET = '{empty: 1'b1, full: 1'b0,
                                                   almost_empty: 1'b1, almost_full: 1'b0};

endpackage

// File: rtl/fifo_status_mem.sv
// B x D register file: synchronous write port, asynchronous read port for
// first-word-fall-through reads.
module fifo_status_mem #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic [W-1:0] r_addr,
    output logic [B-1:0] r_data
);
    localparam int D = 1 << W;

    logic [B-1:0] mem_reg [D];

    // Contents are deliberately left uninitialised; the pointers define validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[w_addr] <= w_data;
        end
    end

    assign r_data = mem_reg[r_addr];

endmodule

// File: rtl/fifo_status.sv
// Synchronous FWFT FIFO with occupancy count, registered level flags and sticky
// overflow/underflow error flags.
module fifo_status
    import fifo_status_pkg::*;
#(
    parameter int B        = 8,
    parameter int W        = 4,
    parameter int AF_LEVEL = default_af_level(W),
    parameter int AE_LEVEL = default_ae_level(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    input  logic         rd,
    input  logic         clr_err,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic         almost_empty,
    output logic         almost_full,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);
    localparam int D  = fifo_depth(W);
    localparam int CW = count_width(W);

    localparam logic [CW-1:0] DEPTH_C = CW'(D);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (AF_LEVEL < 1 || AF_LEVEL > D) begin : g_bad_af_level
        $error("fifo_status: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, D);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > D - 1) begin : g_bad_ae_level
        $error("fifo_status: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, D - 1);
    end

    logic [W-1:0]  w_ptr_reg, w_ptr_next;
    logic [W-1:0]  r_ptr_reg, r_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    level_flags_t  flags_reg, flags_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic          wr_en, rd_en;

    // A write into a full FIFO is still accepted when a read frees the head slot in the same cycle.
    assign rd_en = rd & ~flags_reg.empty;
    assign wr_en = wr & (~flags_reg.full | rd);

    always_comb begin
        w_ptr_next = w_ptr_reg;
        r_ptr_next = r_ptr_reg;
        count_next = count_reg;

        if (wr_en) begin
            w_ptr_next = w_ptr_reg + W'(1);
        end
        if (rd_en) begin
            r_ptr_next = r_ptr_reg + W'(1);
        end

        case ({wr_en, rd_en})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Level flags are computed from the next count so they line up with count every cycle.
    always_comb begin
        flags_next              = LEVEL_FLAGS_RESET;
        flags_next.empty        = (count_next == '0);
        flags_next.full         = (count_next == DEPTH_C);
        flags_next.almost_empty = (count_next <= AE_C);
        flags_next.almost_full  = (count_next >= AF_C);
    end

    // Error flags: a new rejection outranks a simultaneous clear.
    always_comb begin
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (wr & ~wr_en) begin
            overflow_next = 1'b1;
        end else if (clr_err) begin
            overflow_next = 1'b0;
        end

        if (rd & ~rd_en) begin
            underflow_next = 1'b1;
        end else if (clr_err) begin
            underflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr_reg     <= '0;
            r_ptr_reg     <= '0;
            count_reg     <= '0;
            flags_reg     <= LEVEL_FLAGS_RESET;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            w_ptr_reg     <= w_ptr_next;
            r_ptr_reg     <= r_ptr_next;
            count_reg     <= count_next;
            flags_reg     <= flags_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    fifo_status_mem #(
        .B(B),
        .W(W)
    ) u_mem (
        .clk    (clk),
        .we     (wr_en & ~reset),
        .w_addr (w_ptr_reg),
        .w_data (w_data),
        .r_addr (r_ptr_reg),
        .r_data (r_data)
    );

    assign count        = count_reg;
    assign empty        = flags_reg.empty;
    assign full         = flags_reg.full;
    assign almost_empty = flags_reg.almost_empty;
    assign almost_full  = flags_reg.almost_full;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule
